// File: rtl/game_stage_sequencer.sv
// game_stage_sequencer: steps through the game-manager ROM stage table (fetch, wait, run, advance)
// Ports:
//   clk_i, reset_i (async, active-high)
//   start_i (begin at addr 0), tick_i (wait timebase), stage_clear_i (stage finished)
//   update_game_manager_i + rom_* fields from the ROM reader for the presented address
//   addr_o / sync_game_manager_o drive the ROM reader (sync low requests a refresh)
//   stage_o .. display_pos_*_o are the latched stage fields
//   stage_active_o, stage_start_o, busy_o, done_o, fetch_error_o (sticky) are status flags
// Build option: define GAME_SEQ_LOOP_EN to restart from addr 0 at end of table instead of stopping.
module game_stage_sequencer #(
  parameter int         ADDR_WIDTH    = 8,
  parameter int         FETCH_TIMEOUT = 15,
  parameter logic [7:0] END_STAGE     = 8'hFF
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic                  tick_i,
  input  logic                  stage_clear_i,
  input  logic                  update_game_manager_i,
  input  logic [7:0]            rom_stage_i,
  input  logic [9:0]            rom_attack_amount_i,
  input  logic [9:0]            rom_platform_amount_i,
  input  logic [2:0]            rom_gravity_direction_i,
  input  logic [9:0]            rom_display_pos_x1_i,
  input  logic [9:0]            rom_display_pos_y1_i,
  input  logic [9:0]            rom_display_pos_x2_i,
  input  logic [9:0]            rom_display_pos_y2_i,
  input  logic [7:0]            rom_wait_time_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  sync_game_manager_o,
  output logic [7:0]            stage_o,
  output logic [9:0]            attack_amount_o,
  output logic [9:0]            platform_amount_o,
  output logic [2:0]            gravity_direction_o,
  output logic [9:0]            display_pos_x1_o,
  output logic [9:0]            display_pos_y1_o,
  output logic [9:0]            display_pos_x2_o,
  output logic [9:0]            display_pos_y2_o,
  output logic                  stage_active_o,
  output logic                  stage_start_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  fetch_error_o
);
  localparam int CW = $clog2(FETCH_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, FETCH, CHECK, WAIT, ACTIVE, DONE} state_t;
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  err_q, err_d;
  logic [CW-1:0]         fetch_cnt_q;
  logic [7:0]            wait_cnt_q;
  logic                  sync_q, stage_start_q, active_q, busy_q, done_q;
  logic [7:0]            stage_q;
  logic [9:0]            attack_q, platform_q, x1_q, y1_q, x2_q, y2_q;
  logic [2:0]            gravity_q;
  logic                  capture, table_end;
  // an update seen in the first two FETCH cycles may belong to the previous address
  assign capture   = state_q == FETCH && update_game_manager_i && fetch_cnt_q >= CW'(2);
  assign table_end = (state_q == CHECK && stage_q == END_STAGE) ||
                     (state_q == ACTIVE && stage_clear_i && &addr_q);
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    err_d   = err_q;
    case (state_q)
      IDLE, DONE: if (start_i) begin
        state_d = FETCH;
        addr_d  = '0;
        err_d   = 1'b0;
      end
      FETCH: if (capture) state_d = CHECK;
        else if (fetch_cnt_q == CW'(FETCH_TIMEOUT - 1)) begin
          state_d = DONE;
          err_d   = 1'b1;
        end
      CHECK:  state_d = WAIT;
      WAIT:   state_d = wait_cnt_q == '0 ? ACTIVE : WAIT;
      ACTIVE: if (stage_clear_i) begin
        state_d = FETCH;
        addr_d  = addr_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // end marker or last table slot overrides the normal advance (no address wrap)
    if (table_end) begin
`ifdef GAME_SEQ_LOOP_EN
      state_d = FETCH;
      addr_d  = '0;
`else
      state_d = DONE;
      addr_d  = addr_q;
`endif
    end
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      err_q         <= 1'b0;
      fetch_cnt_q   <= '0;
      wait_cnt_q    <= '0;
      sync_q        <= 1'b1;
      stage_start_q <= 1'b0;
      active_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      stage_q       <= '0;
      attack_q      <= '0;
      platform_q    <= '0;
      gravity_q     <= '0;
      x1_q          <= '0;
      y1_q          <= '0;
      x2_q          <= '0;
      y2_q          <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      err_q         <= err_d;
      fetch_cnt_q   <= state_q == FETCH ? fetch_cnt_q + 1'b1 : '0;
      sync_q        <= state_d != FETCH;
      stage_start_q <= state_q == WAIT && state_d == ACTIVE;
      active_q      <= state_d == ACTIVE;
      busy_q        <= !(state_d inside {IDLE, DONE});
      done_q        <= state_d == DONE;
      if (capture) begin
        stage_q    <= rom_stage_i;
        attack_q   <= rom_attack_amount_i;
        platform_q <= rom_platform_amount_i;
        gravity_q  <= rom_gravity_direction_i;
        x1_q       <= rom_display_pos_x1_i;
        y1_q       <= rom_display_pos_y1_i;
        x2_q       <= rom_display_pos_x2_i;
        y2_q       <= rom_display_pos_y2_i;
        wait_cnt_q <= rom_wait_time_i;
      end else if (state_q == WAIT && wait_cnt_q != '0 && tick_i) wait_cnt_q <= wait_cnt_q - 8'd1;
    end
  end
  assign addr_o              = addr_q;
  assign sync_game_manager_o = sync_q;
  assign stage_o             = stage_q;
  assign attack_amount_o     = attack_q;
  assign platform_amount_o   = platform_q;
  assign gravity_direction_o = gravity_q;
  assign display_pos_x1_o    = x1_q;
  assign display_pos_y1_o    = y1_q;
  assign display_pos_x2_o    = x2_q;
  assign display_pos_y2_o    = y2_q;
  assign stage_active_o      = active_q;
  assign stage_start_o       = stage_start_q;
  assign busy_o              = busy_q;
  assign done_o              = done_q;
  assign fetch_error_o       = err_q;
endmodule

// File: tb/tb_game_stage_sequencer.sv
// tb_game_stage_sequencer: randomized table runs against a ROM model and transaction-level expectations
module tb_game_stage_sequencer;
  logic       clk = 1'b0;
  logic       reset_i, start_i, tick_i, stage_clear_i, update_game_manager_i;
  logic [7:0] rom_stage_i, rom_wait_time_i;
  logic [9:0] rom_attack_amount_i, rom_platform_amount_i;
  logic [2:0] rom_gravity_direction_i;
  logic [9:0] rom_display_pos_x1_i, rom_display_pos_y1_i, rom_display_pos_x2_i, rom_display_pos_y2_i;
  logic [7:0] addr_o, stage_o;
  logic       sync_game_manager_o, stage_active_o, stage_start_o, busy_o, done_o, fetch_error_o;
  logic [9:0] attack_amount_o, platform_amount_o;
  logic [2:0] gravity_direction_o;
  logic [9:0] display_pos_x1_o, display_pos_y1_o, display_pos_x2_o, display_pos_y2_o;
  typedef struct packed {
    logic [7:0] stg;
    logic [9:0] atk;
    logic [9:0] plat;
    logic [2:0] grav;
    logic [9:0] x1;
    logic [9:0] y1;
    logic [9:0] x2;
    logic [9:0] y2;
    logic [7:0] wt;
  } ent_t;
  ent_t rom [256];
  int   n_chk = 0, n_fail = 0;
  int   rom_lat = 0, low_cnt = 0;
  bit   rom_mute = 1'b0, rom_stale = 1'b0;
  game_stage_sequencer dut (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .tick_i(tick_i), .stage_clear_i(stage_clear_i),
    .update_game_manager_i(update_game_manager_i), .rom_stage_i(rom_stage_i),
    .rom_attack_amount_i(rom_attack_amount_i), .rom_platform_amount_i(rom_platform_amount_i),
    .rom_gravity_direction_i(rom_gravity_direction_i), .rom_display_pos_x1_i(rom_display_pos_x1_i),
    .rom_display_pos_y1_i(rom_display_pos_y1_i), .rom_display_pos_x2_i(rom_display_pos_x2_i),
    .rom_display_pos_y2_i(rom_display_pos_y2_i), .rom_wait_time_i(rom_wait_time_i),
    .addr_o(addr_o), .sync_game_manager_o(sync_game_manager_o), .stage_o(stage_o),
    .attack_amount_o(attack_amount_o), .platform_amount_o(platform_amount_o),
    .gravity_direction_o(gravity_direction_o), .display_pos_x1_o(display_pos_x1_o),
    .display_pos_y1_o(display_pos_y1_o), .display_pos_x2_o(display_pos_x2_o),
    .display_pos_y2_o(display_pos_y2_o), .stage_active_o(stage_active_o), .stage_start_o(stage_start_o),
    .busy_o(busy_o), .done_o(done_o), .fetch_error_o(fetch_error_o)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic ent_t rnd_ent(input logic [7:0] stg, input logic [7:0] wt);
    ent_t e;
    e.stg  = stg;
    e.wt   = wt;
    e.atk  = 10'($urandom);
    e.plat = 10'($urandom);
    e.grav = 3'($urandom);
    e.x1   = 10'($urandom);
    e.y1   = 10'($urandom);
    e.x2   = 10'($urandom);
    e.y2   = 10'($urandom);
    return e;
  endfunction
  // ROM model: answers update_game_manager rom_lat cycles after sync drops (or always, when stale)
  task automatic cyc(input bit tk, input bit clr, input bit st);
    ent_t e;
    e = rom[addr_o];
    tick_i = tk;
    stage_clear_i = clr;
    start_i = st;
    update_game_manager_i = rom_stale || (!rom_mute && !sync_game_manager_o && low_cnt >= rom_lat);
    {rom_stage_i, rom_attack_amount_i, rom_platform_amount_i, rom_gravity_direction_i,
     rom_display_pos_x1_i, rom_display_pos_y1_i, rom_display_pos_x2_i, rom_display_pos_y2_i,
     rom_wait_time_i} = e;
    @(posedge clk);
    #1;
    low_cnt = sync_game_manager_o ? 0 : low_cnt + 1;
    tick_i = 1'b0;
    stage_clear_i = 1'b0;
    start_i = 1'b0;
  endtask
  task automatic do_reset();
    reset_i = 1'b1;
    cyc(0, 0, 0);
    reset_i = 1'b0;
    cyc(0, 0, 0);
  endtask
  task automatic chk_fields(input int idx);
    chk("stage", stage_o, rom[idx].stg);
    chk("attack", attack_amount_o, rom[idx].atk);
    chk("platform", platform_amount_o, rom[idx].plat);
    chk("gravity", gravity_direction_o, rom[idx].grav);
    chk("x1", display_pos_x1_o, rom[idx].x1);
    chk("y1", display_pos_y1_o, rom[idx].y1);
    chk("x2", display_pos_x2_o, rom[idx].x2);
    chk("y2", display_pos_y2_o, rom[idx].y2);
  endtask
  // called just after the edge that entered FETCH for entry idx
  task automatic run_entry(input int idx, output bit fin);
    int n, exp_n, rem, k;
    bit tk;
    fin = 1'b0;
    chk("fetch_sync_low", sync_game_manager_o, 0);
    chk("fetch_addr", addr_o, idx);
    chk("fetch_busy", busy_o, 1);
    exp_n = rom_stale ? 3 : (rom_lat > 3 ? rom_lat : 3);
    n = 0;
    while (sync_game_manager_o === 1'b0 && n < 40) begin
      cyc($urandom_range(0, 1) == 1, 0, 0);
      n++;
    end
    chk("fetch_latency", n, exp_n);
    chk_fields(idx);
    cyc(0, 0, 0);
    if (rom[idx].stg == 8'hFF) begin
      fin = 1'b1;
`ifdef GAME_SEQ_LOOP_EN
      chk("loop_end_addr", addr_o, 0);
      chk("loop_end_sync", sync_game_manager_o, 0);
      chk("loop_end_done", done_o, 0);
`else
      chk("end_done", done_o, 1);
      chk("end_busy", busy_o, 0);
      chk("end_sync", sync_game_manager_o, 1);
`endif
    end else begin
      chk("wait_no_start", stage_start_o, 0);
      rem = rom[idx].wt;
      n = 0;
      while (rem > 0 && n < 300) begin
        tk = $urandom_range(0, 2) == 0;
        cyc(tk, 0, $urandom_range(0, 3) == 0);
        chk("wait_no_start", stage_start_o, 0);
        if (tk) rem--;
        n++;
      end
      cyc($urandom_range(0, 1) == 1, 0, 0);
      chk("stage_start", stage_start_o, 1);
      chk("stage_active", stage_active_o, 1);
      chk("busy_start_ignored_addr", addr_o, idx);
      k = $urandom_range(1, 3);
      repeat (k) begin
        cyc($urandom_range(0, 1) == 1, 0, $urandom_range(0, 1) == 1);
        chk("active_hold", stage_active_o, 1);
        chk("start_single_pulse", stage_start_o, 0);
      end
      cyc($urandom_range(0, 1) == 1, 1, 0);
      chk("clear_inactive", stage_active_o, 0);
      chk("fields_hold", stage_o, rom[idx].stg);
      if (idx == 255) begin
        fin = 1'b1;
`ifdef GAME_SEQ_LOOP_EN
        chk("last_addr_loop", addr_o, 0);
        chk("last_addr_loop_sync", sync_game_manager_o, 0);
`else
        chk("last_addr_no_wrap", addr_o, 255);
        chk("last_addr_done", done_o, 1);
        chk("last_addr_busy", busy_o, 0);
`endif
      end else begin
        chk("clear_addr", addr_o, idx + 1);
        chk("clear_sync", sync_game_manager_o, 0);
      end
    end
  endtask
  task automatic run_table();
    bit fin;
    int idx;
    cyc(0, 0, 1);
    chk("start_clears_err", fetch_error_o, 0);
    fin = 1'b0;
    idx = 0;
    while (!fin && idx < 300) begin
      run_entry(idx, fin);
      idx++;
    end
`ifdef GAME_SEQ_LOOP_EN
    do_reset();
`endif
  endtask
  initial begin
    int len, n;
    reset_i = 1'b1;
    start_i = 1'b0;
    tick_i = 1'b0;
    stage_clear_i = 1'b0;
    update_game_manager_i = 1'b0;
    {rom_stage_i, rom_attack_amount_i, rom_platform_amount_i, rom_gravity_direction_i,
     rom_display_pos_x1_i, rom_display_pos_y1_i, rom_display_pos_x2_i, rom_display_pos_y2_i,
     rom_wait_time_i} = '0;
    for (int i = 0; i < 256; i++) rom[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_addr", addr_o, 0);
    chk("rst_sync", sync_game_manager_o, 1);
    chk("rst_stage", stage_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", fetch_error_o, 0);
    chk("rst_active", stage_active_o, 0);
    chk("rst_start", stage_start_o, 0);
    reset_i = 1'b0;
    cyc(0, 0, 0);
    cyc(1, 1, 0);
    chk("idle_clear_addr", addr_o, 0);
    chk("idle_clear_busy", busy_o, 0);
    chk("idle_clear_sync", sync_game_manager_o, 1);
    rom[0] = rnd_ent(8'd1, 8'd3);
    rom[1] = rnd_ent(8'hFF, 8'd0);
    run_table();
    rom[0] = rnd_ent(8'd5, 8'd0);
    run_table();
    rom_stale = 1'b1;
    rom[0] = rnd_ent(8'd7, 8'd1);
    rom[1] = rnd_ent(8'd8, 8'd0);
    rom[2] = rnd_ent(8'hFF, 8'd2);
    run_table();
    rom_stale = 1'b0;
    repeat (6) begin
      len = $urandom_range(1, 5);
      for (int i = 0; i < len; i++) rom[i] = rnd_ent(8'($urandom_range(0, 254)), 8'($urandom_range(0, 4)));
      rom[len] = rnd_ent(8'hFF, 8'($urandom_range(0, 4)));
      rom_lat = $urandom_range(0, 6);
      run_table();
    end
    rom_lat = 0;
    rom_mute = 1'b1;
    cyc(0, 0, 1);
    repeat (14) cyc($urandom_range(0, 1) == 1, 0, 0);
    chk("timeout_not_yet", fetch_error_o, 0);
    chk("timeout_still_busy", busy_o, 1);
    chk("timeout_sync_low", sync_game_manager_o, 0);
    cyc(0, 0, 0);
    chk("timeout_err", fetch_error_o, 1);
    chk("timeout_done", done_o, 1);
    chk("timeout_busy", busy_o, 0);
    chk("timeout_sync", sync_game_manager_o, 1);
    cyc(0, 1, 0);
    chk("timeout_sticky", fetch_error_o, 1);
    rom_mute = 1'b0;
    rom[0] = rnd_ent(8'd2, 8'd1);
    rom[1] = rnd_ent(8'hFF, 8'd0);
    run_table();
    rom[0] = rnd_ent(8'd3, 8'd200);
    cyc(0, 0, 1);
    n = 0;
    while (sync_game_manager_o === 1'b0 && n < 40) begin
      cyc(0, 0, 0);
      n++;
    end
    repeat (3) cyc(1, 0, 0);
    chk("pre_reset_busy", busy_o, 1);
    chk("pre_reset_stage", stage_o, 3);
    #2;
    reset_i = 1'b1;
    #1;
    chk("async_rst_addr", addr_o, 0);
    chk("async_rst_sync", sync_game_manager_o, 1);
    chk("async_rst_stage", stage_o, 0);
    chk("async_rst_attack", attack_amount_o, 0);
    chk("async_rst_busy", busy_o, 0);
    chk("async_rst_active", stage_active_o, 0);
    reset_i = 1'b0;
    cyc(1, 0, 0);
    chk("post_rst_idle", busy_o, 0);
    for (int i = 0; i < 256; i++) rom[i] = rnd_ent(8'($urandom_range(0, 254)), 8'd0);
    run_table();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
